// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with 2 write ports and 3 read ports.
// Entry 0 is hardwired to zero. After reset a hardware sequence clears every
// entry, one per cycle, and busy stays high until it finishes. Reads are
// combinational.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports. Write port 1 has priority over write port 0.
module register_file_mp #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WE0,
  input  logic            WE1,
  input  logic [AW-1:0]   WA0,
  input  logic [AW-1:0]   WA1,
  input  logic [XLEN-1:0] WD0,
  input  logic [XLEN-1:0] WD1,
  input  logic [AW-1:0]   RA0,
  input  logic [AW-1:0]   RA1,
  input  logic [AW-1:0]   RA2,
  output logic [XLEN-1:0] RD0,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_ptr_reg, clr_ptr_next;

  // Entry 0 has no storage; its reads are forced to zero.
  logic [XLEN-1:0] mem [1:DEPTH-1];

  // FSM state and clear pointer; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Next-state logic: sweep every entry once, then sit in IDLE until reset.
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    busy         = 1'b0;
    case (state_reg)
      CLEAR: begin
        busy         = 1'b1;
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == {AW{1'b1}}) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Storage update: the clear sweep owns the array while busy; otherwise the
  // user write ports write, and port 1 wins a same-address collision.
  // Nothing is written on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (state_reg == CLEAR) begin
          if (clr_ptr_reg == AW'(i)) begin
            mem[i] <= '0;
          end
        end else if (WE1 && (WA1 == AW'(i))) begin
          mem[i] <= WD1;
        end else if (WE0 && (WA0 == AW'(i))) begin
          mem[i] <= WD0;
        end
      end
    end
  end

  // One read port's view: zero while clearing or for address 0, otherwise
  // the stored value (optionally overridden by same-cycle write data).
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    logic [XLEN-1:0] value;
    value = '0;
    if ((state_reg == IDLE) && (ra != '0)) begin
      value = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (WE1 && (WA1 == ra)) begin
        value = WD1;
      end else if (WE0 && (WA0 == ra)) begin
        value = WD0;
      end
`endif
    end
    return value;
  endfunction

  // Three independent combinational read ports.
  always_comb begin
    RD0 = read_port(RA0);
    RD1 = read_port(RA1);
    RD2 = read_port(RA2);
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed test of register_file_mp (XLEN=32, AW=5).
// Expected values are hand-computed; define REGFILE_BYPASS_EN for both the
// bench and the design to check the forwarding variant.
module tb_register_file_mp;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic            clk;
  logic            rst;
  logic            WE0, WE1;
  logic [AW-1:0]   WA0, WA1;
  logic [XLEN-1:0] WD0, WD1;
  logic [AW-1:0]   RA0, RA1, RA2;
  logic [XLEN-1:0] RD0, RD1, RD2;
  logic            busy;

  int errors = 0;
  int checks = 0;

  register_file_mp #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .WE0(WE0), .WE1(WE1),
    .WA0(WA0), .WA1(WA1),
    .WD0(WD0), .WD1(WD1),
    .RA0(RA0), .RA1(RA1), .RA2(RA2),
    .RD0(RD0), .RD1(RD1), .RD2(RD2),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE0 = 1'b0; WE1 = 1'b0;
    WA0 = '0; WA1 = '0; WD0 = '0; WD1 = '0;
  endtask

  // Count rising edges until busy falls, bounded at 100.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    RA0 = 5'd1; RA1 = 5'd17; RA2 = 5'd31;
    rst = 1'b1;
    step(); step(); step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_in_rst: got %b want 1", busy);
    end
    checks++;
    if (RD0 !== '0 || RD1 !== '0 || RD2 !== '0) begin
      errors++; $display("FAIL reset_rd_in_rst: got %h %h %h want 0", RD0, RD1, RD2);
    end
    rst = 1'b0;
    count_busy(n);
    $display("reset: busy fell after %0d edges", n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL reset_busy_len: got %0d want %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      RA0 = AW'(a);
      #1;
      checks++;
      if (RD0 !== '0) begin
        errors++; $display("FAIL reset_entry_%0d: got %h want 0", a, RD0);
      end
    end
  endtask

  task automatic test_basic();
    logic [XLEN-1:0] exp_same;
    WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hDEADBEEF; RA1 = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    $display("write p0 addr=5 data=deadbeef, same-cycle RD1=%h", RD1);
    checks++;
    if (RD1 !== exp_same) begin
      errors++; $display("FAIL basic_same_cycle: got %h want %h", RD1, exp_same);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (RD1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_next_cycle: got %h want deadbeef", RD1);
    end
    // Overwrite while reading: pre-edge value unless forwarding is enabled.
    WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h12345678;
`else
    exp_same = 32'hDEADBEEF;
`endif
    checks++;
    if (RD1 !== exp_same) begin
      errors++; $display("FAIL basic_overwrite_same: got %h want %h", RD1, exp_same);
    end
    step();
    idle_inputs();
    RA0 = 5'd5; RA2 = 5'd5;
    #1;
    $display("read addr=5 on three ports: %h %h %h", RD0, RD1, RD2);
    checks++;
    if (RD0 !== 32'h12345678 || RD1 !== 32'h12345678 || RD2 !== 32'h12345678) begin
      errors++; $display("FAIL basic_three_ports: got %h %h %h want 12345678", RD0, RD1, RD2);
    end
  endtask

  task automatic test_collision();
    logic [XLEN-1:0] exp_same;
    WE0 = 1'b1; WE1 = 1'b1; WA0 = 5'd7; WA1 = 5'd7;
    WD0 = 32'h11; WD1 = 32'h22; RA0 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h0;
`endif
    $display("collision addr=7 p0=11 p1=22, same-cycle RD0=%h", RD0);
    checks++;
    if (RD0 !== exp_same) begin
      errors++; $display("FAIL collision_same_cycle: got %h want %h", RD0, exp_same);
    end
    step();
    // Two different addresses written on one edge.
    WA0 = 5'd8; WD0 = 32'hA; WA1 = 5'd31; WD1 = 32'hB;
    #1;
    checks++;
    if (RD0 !== 32'h22) begin
      errors++; $display("FAIL collision_result: got %h want 22", RD0);
    end
    step();
    idle_inputs();
    RA0 = 5'd8; RA1 = 5'd31; RA2 = 5'd7;
    #1;
    $display("dual write: entry8=%h entry31=%h entry7=%h", RD0, RD1, RD2);
    checks++;
    if (RD0 !== 32'hA) begin
      errors++; $display("FAIL dual_write_p0: got %h want a", RD0);
    end
    checks++;
    if (RD1 !== 32'hB) begin
      errors++; $display("FAIL dual_write_p1_top_entry: got %h want b", RD1);
    end
    checks++;
    if (RD2 !== 32'h22) begin
      errors++; $display("FAIL dual_write_keep7: got %h want 22", RD2);
    end
  endtask

  task automatic test_x0();
    WE0 = 1'b1; WA0 = 5'd0; WD0 = 32'hFFFFFFFF;
    WE1 = 1'b1; WA1 = 5'd0; WD1 = 32'hFFFFFFFF;
    RA2 = 5'd0;
    #1;
    $display("write x0 with ffffffff, same-cycle RD2=%h", RD2);
    checks++;
    if (RD2 !== '0) begin
      errors++; $display("FAIL x0_same_cycle: got %h want 0", RD2);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (RD2 !== '0) begin
      errors++; $display("FAIL x0_next_cycle: got %h want 0", RD2);
    end
  endtask

  task automatic test_write_during_clear();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    WE1 = 1'b1; WA1 = 5'd3; WD1 = 32'h55;
    WE0 = 1'b1; WA0 = 5'd9; WD0 = 32'h66;
    RA0 = 5'd8; RA1 = 5'd31; RA2 = 5'd3;
    #1;
    checks++;
    if (RD0 !== '0 || RD1 !== '0 || RD2 !== '0) begin
      errors++; $display("FAIL clear_rd_zero: got %h %h %h want 0", RD0, RD1, RD2);
    end
    count_busy(n);
    idle_inputs();
    RA0 = 5'd3; RA1 = 5'd9; RA2 = 5'd8;
    #1;
    $display("writes during clear: entry3=%h entry9=%h entry8=%h", RD0, RD1, RD2);
    checks++;
    if (n != DEPTH - 2) begin
      errors++; $display("FAIL clear_busy_len: got %0d want %0d", n, DEPTH - 2);
    end
    checks++;
    if (RD0 !== '0 || RD1 !== '0) begin
      errors++; $display("FAIL clear_write_ignored: got %h %h want 0", RD0, RD1);
    end
    checks++;
    if (RD2 !== '0) begin
      errors++; $display("FAIL clear_old_data: got %h want 0", RD2);
    end
  endtask

  task automatic test_mid_clear_reset();
    int n;
    WE0 = 1'b1; WA0 = 5'd20; WD0 = 32'hCAFEF00D;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midclear_busy_at10: got %b want 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    RA0 = 5'd20;
    #1;
    $display("reset mid-clear: busy fell after %0d edges, entry20=%h", n, RD0);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL midclear_busy_len: got %0d want %0d", n, DEPTH);
    end
    checks++;
    if (RD0 !== '0) begin
      errors++; $display("FAIL midclear_entry20: got %h want 0", RD0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    RA0 = '0; RA1 = '0; RA2 = '0;
    test_reset();
    test_basic();
    test_collision();
    test_x0();
    test_write_during_clear();
    test_mid_clear_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every register in bits.
REQ-002 SHALL have parameter AW, default 5, address width; depth DEPTH = 2**AW entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports WE0, WE1  input  1 each  write enables for write ports 0 and 1.
REQ-006 SHALL have ports WA0, WA1  input  AW each  write addresses.
REQ-007 SHALL have ports WD0, WD1  input  XLEN each  write data.
REQ-008 SHALL have ports RA0, RA1, RA2  input  AW each  read addresses.
REQ-009 SHALL have ports RD0, RD1, RD2  output  XLEN each  read data, combinational.
REQ-010 SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-011 SHALL implement a two-state FSM: CLEAR and IDLE; busy = 1 exactly when state is CLEAR.
REQ-012 SHALL, in CLEAR, write zero to entry clr_ptr each cycle and increment clr_ptr by 1, with clr_ptr AW bits wide.
REQ-013 SHALL move CLEAR -> IDLE on the edge where entry DEPTH-1 is cleared; IDLE persists until rst.
REQ-014 SHALL ignore WE0/WE1 completely while busy = 1, with no deferred writes.
REQ-015 SHALL drive RD0/RD1/RD2 = 0 while busy = 1, regardless of addresses.
REQ-016 SHALL, in IDLE, write WDn to entry WAn on the clock edge when WEn = 1 (write latency 1 cycle).
REQ-017 SHALL never write entry 0; a read of address 0 SHALL always return 0 (x0 hardwired).
REQ-018 SHALL, when WE0 = WE1 = 1 and WA0 = WA1, store WD1 (port 1 wins); different addresses SHALL both be written the same edge.
REQ-019 SHALL serve all three read ports independently; identical RA values return identical data.
REQ-020 SHALL, without bypass, return the pre-edge stored value for a read of an address being written that cycle.

Reset
REQ-021 SHALL, on any edge with rst = 1, set state = CLEAR and clr_ptr = 0; no entry is written on that edge.
REQ-022 SHALL hold busy = 1 and RDn = 0 during and after rst until the clear finishes: DEPTH cycles after the first edge with rst = 0.
REQ-023 SHALL restart the clear from entry 0 if rst is asserted mid-clear or in IDLE.
REQ-024 SHALL leave every entry reading 0 once busy falls, independent of power-up contents.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, forward in IDLE to each read port RDn = WD1 if WE1 and WA1 = RAn != 0, else WD0 if WE0 and WA0 = RAn != 0, else the stored value.
REQ-026 SHALL, without REGFILE_BYPASS_EN, omit all forwarding logic and behave per REQ-020.
REQ-027 SHALL apply no forwarding while busy = 1 and none for address 0, whether or not the macro is defined.

Verification
REQ-028 SHALL cover reset clear: AW=5, rst high 3 cycles then low -> busy high exactly 32 cycles after release, then all 32 entries read 0.
REQ-029 SHALL cover basic write/read: WE0=1, WA0=5, WD0=0xDEADBEEF, next cycle RA1=5 -> RD1=0xDEADBEEF; same cycle RA1=5 -> old value (no macro) or 0xDEADBEEF (macro).
REQ-030 SHALL cover a write collision: WE0=WE1=1, WA0=WA1=7, WD0=0x11, WD1=0x22 -> entry 7 reads 0x22; with macro, same-cycle RA0=7 -> 0x22.
REQ-031 SHALL cover x0: WE0=1, WA0=0, WD0=0xFFFFFFFF -> RA2=0 reads 0 both same cycle and next cycle.
REQ-032 SHALL cover writes during clear: WE1=1, WA1=3, WD1=0x55 issued while busy -> entry 3 reads 0 after busy falls.
REQ-033 SHALL cover reset mid-clear: rst asserted 10 cycles into the clear -> clr_ptr returns to 0 and busy stays high another 32 cycles after release.
